// File: rtl/bsg_store_and_forward_pkt.sv
// Packet store-and-forward buffer: speculative circular write, release on commit of last word.
// Optional statistics counters are built only when BSG_SAF_STATS_EN is defined.
module bsg_store_and_forward_pkt #(
    parameter int unsigned width_p                 = 8,
    parameter int unsigned els_p                   = 8,
    parameter int unsigned pkt_els_p               = 4,
    parameter int unsigned max_len_p               = els_p,
    parameter int unsigned write_no_backpressure_p = 0,
    parameter int unsigned drop_error_p            = 0,
    parameter int unsigned count_width_p           = 16
) (
    input  logic                               clk_i,
    input  logic                               reset_i,
    input  logic [width_p-1:0]                 data_i,
    input  logic                               v_i,
    input  logic                               last_i,
    input  logic                               error_i,
    output logic                               ready_o,
    output logic [width_p-1:0]                 data_o,
    output logic                               v_o,
    output logic                               last_o,
    input  logic                               yumi_i,
    output logic                               good_packet_o,
    output logic                               bad_packet_o,
    output logic                               incomplete_packet_o,
    output logic                               oversize_packet_o,
    output logic [$clog2(pkt_els_p+1)-1:0]     pkt_count_o,
    output logic [count_width_p-1:0]           stat_good_o,
    output logic [count_width_p-1:0]           stat_drop_o
);

    localparam int unsigned PtrW = $clog2(els_p);
    localparam int unsigned OccW = $clog2(els_p + 1);
    localparam int unsigned PcW  = $clog2(pkt_els_p + 1);
    localparam int unsigned LenW = $clog2(max_len_p + 2);
    localparam bit          Bp   = (write_no_backpressure_p != 0);
    localparam bit          DropErr = (drop_error_p != 0);

    typedef enum logic [1:0] {StIdle, StRecv, StDrop} state_e;

    state_e            state_q, state_d;
    logic [PtrW-1:0]   rptr_q, rptr_d, wptr_c_q, wptr_c_d, wptr_s_q, wptr_s_d;
    logic [OccW-1:0]   occ_q, occ_d, occ_c_q, occ_c_d;
    logic [PcW-1:0]    pkt_count_q, pkt_count_d;
    logic [LenW-1:0]   len_q, len_d, len_inc;
    logic              commit_q;
    logic              good_q, good_d, bad_q, bad_d, over_q, over_d, inc_q, inc_d;

    logic [width_p:0]  mem_q [els_p];
    logic [width_p:0]  rd_q;

    logic full, cnt_full, enq, yumi, yumi_last, in_pkt, drop_trig, write;
    logic commit, err_drop, rollback, drop_end, len_over;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(els_p - 1)) ? '0 : p + PtrW'(1);
    endfunction

    assign full     = (occ_q == OccW'(els_p));
    assign cnt_full = (pkt_count_q == PcW'(pkt_els_p));
    // Independent of yumi_i so there is no combinational path from consumer to producer.
    assign ready_o  = Bp | (state_q == StDrop) | (~full & ~((state_q == StIdle) & cnt_full))
                    | (full & (occ_c_q == '0));

    assign enq       = v_i & ready_o;
    assign yumi      = yumi_i & v_o;
    assign yumi_last = yumi & last_o;
    assign in_pkt    = (state_q != StDrop);
    assign len_inc   = (len_q == LenW'(max_len_p + 1)) ? len_q : len_q + LenW'(1);
    assign len_over  = (len_inc > LenW'(max_len_p));

    assign drop_trig = enq & in_pkt & ((full & Bp) | (full & (occ_c_q == '0))
                     | (len_q == LenW'(max_len_p)) | ((state_q == StIdle) & cnt_full & Bp));
    assign write     = enq & in_pkt & ~drop_trig;
    assign commit    = write & last_i & ~(DropErr & error_i);
    assign err_drop  = write & last_i & DropErr & error_i;
    assign rollback  = drop_trig | err_drop;
    assign drop_end  = enq & last_i & ((state_q == StDrop) | drop_trig);

    always_comb begin
        state_d     = state_q;
        rptr_d      = yumi ? ptr_inc(rptr_q) : rptr_q;
        wptr_c_d    = commit ? ptr_inc(wptr_s_q) : wptr_c_q;
        wptr_s_d    = wptr_s_q;
        occ_d       = occ_q + OccW'(write) - OccW'(yumi);
        occ_c_d     = occ_c_q - OccW'(yumi);
        pkt_count_d = pkt_count_q + PcW'(commit) - PcW'(yumi_last);
        len_d       = len_q;
        if (rollback) begin
            wptr_s_d = wptr_c_q;
            occ_d    = occ_c_q - OccW'(yumi);
        end else if (write) begin
            wptr_s_d = ptr_inc(wptr_s_q);
        end
        if (commit) begin
            occ_c_d = occ_q + OccW'(1) - OccW'(yumi);
        end
        if (enq) begin
            len_d = last_i ? '0 : len_inc;
            if (last_i) begin
                state_d = StIdle;
            end else if (!in_pkt || drop_trig) begin
                state_d = StDrop;
            end else begin
                state_d = StRecv;
            end
        end
        good_d = commit & ~error_i;
        bad_d  = (commit & error_i) | err_drop;
        over_d = drop_end & len_over;
        inc_d  = drop_end & ~len_over;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= StIdle;
            rptr_q      <= '0;
            wptr_c_q    <= '0;
            wptr_s_q    <= '0;
            occ_q       <= '0;
            occ_c_q     <= '0;
            pkt_count_q <= '0;
            len_q       <= '0;
            commit_q    <= 1'b0;
            good_q      <= 1'b0;
            bad_q       <= 1'b0;
            over_q      <= 1'b0;
            inc_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            rptr_q      <= rptr_d;
            wptr_c_q    <= wptr_c_d;
            wptr_s_q    <= wptr_s_d;
            occ_q       <= occ_d;
            occ_c_q     <= occ_c_d;
            pkt_count_q <= pkt_count_d;
            len_q       <= len_d;
            commit_q    <= commit;
            good_q      <= good_d;
            bad_q       <= bad_d;
            over_q      <= over_d;
            inc_q       <= inc_d;
        end
    end

    // Read register always tracks the next head so output words stream without bubbles.
    always_ff @(posedge clk_i) begin
        if (write) begin
            mem_q[wptr_s_q] <= {last_i, data_i};
        end
        rd_q <= mem_q[rptr_d];
    end

    // A fresh commit becomes visible one cycle later, once the read register holds its head word.
    assign v_o    = (pkt_count_q != '0) & ~(commit_q & (pkt_count_q == PcW'(1)));
    assign data_o = rd_q[width_p-1:0];
    assign last_o = rd_q[width_p];

    assign good_packet_o       = good_q;
    assign bad_packet_o        = bad_q;
    assign incomplete_packet_o = inc_q;
    assign oversize_packet_o   = over_q;
    assign pkt_count_o         = pkt_count_q;

`ifdef BSG_SAF_STATS_EN
    logic [count_width_p-1:0] stat_good_q, stat_drop_q;
    logic                     drop_evt;

    assign drop_evt = over_d | inc_d | err_drop;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            stat_good_q <= '0;
            stat_drop_q <= '0;
        end else begin
            if (good_d && !(&stat_good_q)) stat_good_q <= stat_good_q + count_width_p'(1);
            if (drop_evt && !(&stat_drop_q)) stat_drop_q <= stat_drop_q + count_width_p'(1);
        end
    end

    assign stat_good_o = stat_good_q;
    assign stat_drop_o = stat_drop_q;
`else
    assign stat_good_o = '0;
    assign stat_drop_o = '0;
`endif

endmodule

// File: tb/tb_bsg_store_and_forward_pkt.sv
// Bench for bsg_store_and_forward_pkt: packet table plus hand sequences, output words scoreboarded.
module tb_bsg_store_and_forward_pkt;

`ifdef BSG_SAF_STATS_EN
    localparam bit StatsOn = 1'b1;
`else
    localparam bit StatsOn = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    // dut0: els 8, pkt_els 2, max_len 4, backpressure, drop errors
    logic [7:0]  d0, dout0;
    logic        v0, last0, err0, ready0, vo0, lasto0, yumi0;
    logic        good0, bad0, inc0, over0;
    logic [1:0]  pc0;
    logic [15:0] sg0, sd0;
    // dut1: els 8, pkt_els 4, max_len 16, no backpressure
    logic [7:0]  d1, dout1;
    logic        v1, last1, err1, ready1, vo1, lasto1, yumi1;
    logic        good1, bad1, inc1, over1;
    logic [2:0]  pc1;
    logic [15:0] sg1, sd1;

    bsg_store_and_forward_pkt #(
        .width_p(8), .els_p(8), .pkt_els_p(2), .max_len_p(4),
        .write_no_backpressure_p(0), .drop_error_p(1), .count_width_p(16)
    ) dut0 (
        .clk_i(clk), .reset_i(reset), .data_i(d0), .v_i(v0), .last_i(last0), .error_i(err0),
        .ready_o(ready0), .data_o(dout0), .v_o(vo0), .last_o(lasto0), .yumi_i(yumi0),
        .good_packet_o(good0), .bad_packet_o(bad0), .incomplete_packet_o(inc0),
        .oversize_packet_o(over0), .pkt_count_o(pc0), .stat_good_o(sg0), .stat_drop_o(sd0)
    );

    bsg_store_and_forward_pkt #(
        .width_p(8), .els_p(8), .pkt_els_p(4), .max_len_p(16),
        .write_no_backpressure_p(1), .drop_error_p(0), .count_width_p(16)
    ) dut1 (
        .clk_i(clk), .reset_i(reset), .data_i(d1), .v_i(v1), .last_i(last1), .error_i(err1),
        .ready_o(ready1), .data_o(dout1), .v_o(vo1), .last_o(lasto1), .yumi_i(yumi1),
        .good_packet_o(good1), .bad_packet_o(bad1), .incomplete_packet_o(inc1),
        .oversize_packet_o(over1), .pkt_count_o(pc1), .stat_good_o(sg1), .stat_drop_o(sd1)
    );

    typedef struct {
        int         len;
        bit         err;
        logic [3:0] exp_pulse;  // {good, bad, oversize, incomplete}
        bit         push;
    } vec_t;

    vec_t       tbl[6];
    logic [8:0] sb_q[$];
    int         n_vec = 0;
    int         n_err = 0;
    bit         auto_yumi;
    logic       man_yumi;
    bit         acc0;
    bit         ready_low;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    // One clock: settle, drive yumi, check any consumed word, cross the edge, sample at +1.
    task automatic tick();
        logic [8:0] e;
        #1;
        yumi0 = auto_yumi ? vo0 : man_yumi;
        acc0  = v0 & ready0;
        if (vo0 && yumi0) begin
            if (sb_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL sb_unexpected: got %0h required no output", {lasto0, dout0});
            end else begin
                e = sb_q.pop_front();
                check("sb_word", 32'({lasto0, dout0}), 32'(e));
            end
        end
        @(posedge clk);
        #1;
        yumi0 = 1'b0;
    endtask

    task automatic send_pkt0(input int len, input bit err, input logic [7:0] base, input bit push);
        int k;
        for (int i = 0; i < len; i++) begin
            v0    = 1'b1;
            d0    = base + 8'(i);
            last0 = (i == len - 1);
            err0  = err && (i == len - 1);
            k = 0;
            do begin
                tick();
                k++;
            end while (!acc0 && k < 50);
            if (!acc0) check("send_timeout", 32'(0), 32'(1));
            else if (push) sb_q.push_back({last0, d0});
        end
        v0 = 1'b0; last0 = 1'b0; err0 = 1'b0;
    endtask

    task automatic drain0();
        int k = 0;
        while (sb_q.size() != 0 && k < 100) begin
            tick();
            k++;
        end
        check("drain_empty", 32'(sb_q.size()), 32'(0));
        tick();
        tick();
        check("drain_pkt_count", 32'(pc0), 32'(0));
        check("drain_v_o", 32'(vo0), 32'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{5, 1'b0, 4'b0010, 1'b0};
        tbl[1] = '{2, 1'b0, 4'b1000, 1'b1};
        tbl[2] = '{3, 1'b1, 4'b0100, 1'b0};
        tbl[3] = '{1, 1'b0, 4'b1000, 1'b1};
        tbl[4] = '{4, 1'b0, 4'b1000, 1'b1};
        tbl[5] = '{4, 1'b1, 4'b0100, 1'b0};

        reset = 1'b1;
        v0 = 0; d0 = 0; last0 = 0; err0 = 0; yumi0 = 0;
        v1 = 0; d1 = 0; last1 = 0; err1 = 0; yumi1 = 0;
        auto_yumi = 1'b0; man_yumi = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        check("rst_v_o", 32'(vo0), 32'(0));
        check("rst_ready", 32'(ready0), 32'(1));
        check("rst_pkt_count", 32'(pc0), 32'(0));
        check("rst_pulses", 32'({good0, bad0, over0, inc0}), 32'(0));
        check("rst_v_o1", 32'(vo1), 32'(0));

        // 3-word packet, consumer always ready
        auto_yumi = 1'b1;
        send_pkt0(3, 1'b0, 8'h10, 1'b1);
        check("t1_pulse", 32'({good0, bad0, over0, inc0}), 32'b1000);
        check("t1_pkt_count", 32'(pc0), 32'(1));
        check("t1_v_o_early", 32'(vo0), 32'(0));
        tick();
        check("t1_v_o_rise", 32'(vo0), 32'(1));
        drain0();

        for (int i = 0; i < 6; i++) begin
            send_pkt0(tbl[i].len, tbl[i].err, 8'(32 + 16 * i), tbl[i].push);
            check("tbl_pulse", 32'({good0, bad0, over0, inc0}), 32'(tbl[i].exp_pulse));
            tick();
            check("tbl_pulse_clear", 32'({good0, bad0, over0, inc0}), 32'(0));
            drain0();
        end

        // pkt_els_p=2 with stalled consumer
        auto_yumi = 1'b0;
        send_pkt0(1, 1'b0, 8'hA0, 1'b1);
        send_pkt0(1, 1'b0, 8'hA1, 1'b1);
        check("t5_ready_low", 32'(ready0), 32'(0));
        check("t5_pkt_count", 32'(pc0), 32'(2));
        v0 = 1'b1; d0 = 8'hA2; last0 = 1'b1;
        tick();
        check("t5_stall_a", 32'(acc0), 32'(0));
        tick();
        check("t5_stall_b", 32'(acc0), 32'(0));
        check("t5_v_o", 32'(vo0), 32'(1));
        man_yumi = 1'b1;
        tick();
        man_yumi = 1'b0;
        check("t5_ready_reraise", 32'(ready0), 32'(1));
        tick();
        check("t5_accept", 32'(acc0), 32'(1));
        if (acc0) sb_q.push_back({1'b1, 8'hA2});
        v0 = 1'b0; last0 = 1'b0;
        auto_yumi = 1'b1;
        drain0();
        check("stat_good0", 32'(sg0), StatsOn ? 32'(7) : 32'(0));
        check("stat_drop0", 32'(sd0), StatsOn ? 32'(3) : 32'(0));

        // no-backpressure instance: 10-word packet overflows an 8-word buffer
        ready_low = 1'b0;
        for (int i = 0; i < 10; i++) begin
            v1 = 1'b1; d1 = 8'(i); last1 = (i == 9);
            #1;
            if (!ready1) ready_low = 1'b1;
            tick();
        end
        v1 = 1'b0; last1 = 1'b0;
        check("t2_pulse", 32'({good1, bad1, over1, inc1}), 32'b0001);
        check("t2_ready_never_low", 32'(ready_low), 32'(0));
        tick();
        tick();
        check("t2_pkt_count", 32'(pc1), 32'(0));
        check("t2_v_o", 32'(vo1), 32'(0));
        check("t2_stat_drop", 32'(sd1), StatsOn ? 32'(1) : 32'(0));

        // two committed packets plus one partial, then reset
        for (int i = 0; i < 6; i++) begin
            v1 = 1'b1; d1 = 8'(8'h50 + i); last1 = (i == 1) || (i == 3);
            tick();
            if (i == 3) begin
                v1 = 1'b0;
                tick();
                tick();
                check("t6_pkt_count_pre", 32'(pc1), 32'(2));
                check("t6_v_o_pre", 32'(vo1), 32'(1));
                check("t6_head_word", 32'({lasto1, dout1}), 32'h050);
            end
        end
        v1 = 1'b0; last1 = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("t6_v_o", 32'(vo1), 32'(0));
        check("t6_pkt_count", 32'(pc1), 32'(0));
        check("t6_ready", 32'(ready1), 32'(1));
        check("t6_stat_good", 32'(sg1), 32'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
